// File: rtl/pos_ctrl_pkg.sv
// Shared definitions for the position controller: handshake state encoding
// and step-direction codes.
package pos_ctrl_pkg;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_NOTIFY = 1'b1
   } state_t;

   localparam logic DIR_LEFT  = 1'b0;
   localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/pos_ctrl_step.sv
// Combinational one-position step with wrap-around or saturation at the
// ends of 0..POS_MAX.
module pos_step
   import pos_ctrl_pkg::*;
#(
   parameter int POS_W   = 4,
   parameter int POS_MAX = 9,
   parameter bit WRAP    = 1'b1
) (
   input  logic [POS_W-1:0] pos,
   input  logic             dir,
   output logic [POS_W-1:0] next_pos,
   output logic             blocked
);

   localparam logic [POS_W-1:0] MAX_V  = POS_W'(POS_MAX);
   localparam logic [POS_W-1:0] ZERO_V = {POS_W{1'b0}};

   // Next position and end-stop detection for one step in direction dir
   always_comb begin
      next_pos = pos;
      blocked  = 1'b0;
      if (dir == DIR_RIGHT) begin
         if (pos == MAX_V) begin
            if (WRAP) begin
               next_pos = ZERO_V;
            end else begin
               blocked = 1'b1;
            end
         end else begin
            next_pos = pos + POS_W'(1);
         end
      end else begin
         if (pos == ZERO_V) begin
            if (WRAP) begin
               next_pos = MAX_V;
            end else begin
               blocked = 1'b1;
            end
         end else begin
            next_pos = pos - POS_W'(1);
         end
      end
   end

endmodule

// File: rtl/pos_ctrl.sv
// Player position register fed by left/right/restart pulses; every accepted
// update is offered to the display stage via a valid/ack handshake.
module pos_ctrl
   import pos_ctrl_pkg::*;
#(
   parameter int POS_W     = 4,
   parameter int POS_MAX   = 9,
   parameter int START_POS = 0,
   parameter bit WRAP      = 1'b1,
   parameter int MOV_W     = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             en_i,
   input  logic             left_i,
   input  logic             right_i,
   input  logic             clr_i,
   input  logic             ack_i,
   output logic [POS_W-1:0] pos_o,
   output logic [MOV_W-1:0] moves_o,
   output logic             upd_o,
   output logic             edge_o,
   output logic             drop_o
);

   localparam logic [POS_W-1:0] START_V = POS_W'(START_POS);
   localparam logic [MOV_W-1:0] MOV_MAX = {MOV_W{1'b1}};

   state_t           state;
   logic [POS_W-1:0] next_pos;
   logic             blocked;
   logic             step;

   // Simultaneous left and right cancel each other out
   assign step = en_i & (left_i ^ right_i);

   pos_step #(
      .POS_W   (POS_W),
      .POS_MAX (POS_MAX),
      .WRAP    (WRAP)
   ) u_step (
      .pos      (pos_o),
      .dir      (right_i),
      .next_pos (next_pos),
      .blocked  (blocked)
   );

   // Handshake FSM with position, move counter and status pulse registers
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state   <= ST_IDLE;
         pos_o   <= START_V;
         moves_o <= {MOV_W{1'b0}};
         upd_o   <= 1'b0;
         edge_o  <= 1'b0;
         drop_o  <= 1'b0;
      end else begin
         edge_o <= 1'b0;
         drop_o <= 1'b0;
         if (en_i && clr_i) begin
            // Restart always publishes a fresh update, even over an ack
            pos_o   <= START_V;
            moves_o <= {MOV_W{1'b0}};
            upd_o   <= 1'b1;
            state   <= ST_NOTIFY;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (step) begin
                     if (blocked) begin
                        edge_o <= 1'b1;
                     end else begin
                        pos_o <= next_pos;
                        if (moves_o != MOV_MAX) begin
                           moves_o <= moves_o + MOV_W'(1);
                        end
                        upd_o <= 1'b1;
                        state <= ST_NOTIFY;
                     end
                  end
               end
               ST_NOTIFY: begin
                  if (step) begin
                     drop_o <= 1'b1;
                  end
                  if (ack_i) begin
                     upd_o <= 1'b0;
                     state <= ST_IDLE;
                  end
               end
               default: begin
                  upd_o <= 1'b0;
                  state <= ST_IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_pos_ctrl.sv
// Directed bench for pos_ctrl: three instances (wrap, saturate, 2-bit
// move counter) share pulses and are individually enabled.
module tb_pos_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic left = 1'b0, right = 1'b0, clr = 1'b0, ack = 1'b0;
   logic en0 = 1'b0, en1 = 1'b0, en2 = 1'b0;

   logic [3:0] pos0, pos1, pos2;
   logic [7:0] mov0, mov1;
   logic [1:0] mov2;
   logic       upd0, upd1, upd2, edg0, edg1, edg2, drp0, drp1, drp2;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   pos_ctrl dut_wrap (
      .clk_i(clk), .rst_i(rst), .en_i(en0), .left_i(left), .right_i(right),
      .clr_i(clr), .ack_i(ack), .pos_o(pos0), .moves_o(mov0), .upd_o(upd0),
      .edge_o(edg0), .drop_o(drp0));

   pos_ctrl #(.WRAP(1'b0)) dut_sat (
      .clk_i(clk), .rst_i(rst), .en_i(en1), .left_i(left), .right_i(right),
      .clr_i(clr), .ack_i(ack), .pos_o(pos1), .moves_o(mov1), .upd_o(upd1),
      .edge_o(edg1), .drop_o(drp1));

   pos_ctrl #(.MOV_W(2)) dut_m2 (
      .clk_i(clk), .rst_i(rst), .en_i(en2), .left_i(left), .right_i(right),
      .clr_i(clr), .ack_i(ack), .pos_o(pos2), .moves_o(mov2), .upd_o(upd2),
      .edge_o(edg2), .drop_o(drp2));

   task automatic check(input string tag, input int got, input int exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic step(input logic l, input logic r);
      left  = l;
      right = r;
      tick();
      left  = 1'b0;
      right = 1'b0;
   endtask

   task automatic do_ack();
      ack = 1'b1;
      tick();
      ack = 1'b0;
   endtask

   initial begin
      tick();
      tick();
      rst = 1'b0;
      check("rst_pos", pos0, 0);
      check("rst_moves", mov0, 0);
      check("rst_upd", upd0, 0);
      check("rst_edge", edg0, 0);
      check("rst_drop", drp0, 0);

      // Three rights, each acknowledged two cycles after upd rises
      en0 = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         step(1'b0, 1'b1);
         check("r3_pos", pos0, i);
         check("r3_moves", mov0, i);
         check("r3_upd_c1", upd0, 1);
         tick();
         check("r3_upd_c2", upd0, 1);
         tick();
         check("r3_upd_c3", upd0, 1);
         do_ack();
         check("r3_upd_low", upd0, 0);
         check("r3_pos_hold", pos0, i);
      end

      // Restart, then wrap-around on left at 0
      clr = 1'b1;
      tick();
      clr = 1'b0;
      check("clr_pos", pos0, 0);
      check("clr_moves", mov0, 0);
      check("clr_upd", upd0, 1);
      do_ack();
      step(1'b1, 1'b0);
      check("wrap_pos", pos0, 9);
      check("wrap_moves", mov0, 1);

      // Pulse while NOTIFY without ack is dropped
      step(1'b0, 1'b1);
      check("drop_pulse", drp0, 1);
      check("drop_pos", pos0, 9);
      check("drop_upd", upd0, 1);
      tick();
      check("drop_once", drp0, 0);
      do_ack();

      // Left and right together cancel
      step(1'b1, 1'b1);
      check("both_pos", pos0, 9);
      check("both_upd", upd0, 0);
      check("both_edge", edg0, 0);
      check("both_drop", drp0, 0);
      check("both_moves", mov0, 1);

      // Walk to pos 5 with 7 moves, then restart together with right
      for (int i = 0; i < 6; i++) begin
         step(1'b0, 1'b1);
         do_ack();
      end
      check("walk_pos", pos0, 5);
      check("walk_moves", mov0, 7);
      clr   = 1'b1;
      right = 1'b1;
      tick();
      clr   = 1'b0;
      right = 1'b0;
      check("clrr_pos", pos0, 0);
      check("clrr_moves", mov0, 0);
      check("clrr_upd", upd0, 1);
      // Restart with ack in NOTIFY keeps a fresh update pending
      clr = 1'b1;
      ack = 1'b1;
      tick();
      clr = 1'b0;
      ack = 1'b0;
      check("clrack_upd", upd0, 1);
      do_ack();
      check("clrack_done", upd0, 0);

      // Disabled input stage ignores pulses
      en0 = 1'b0;
      step(1'b0, 1'b1);
      check("dis_pos", pos0, 0);
      check("dis_upd", upd0, 0);
      check("dis_moves", mov0, 0);

      // Saturating instance: blocked at both ends
      en1 = 1'b1;
      step(1'b1, 1'b0);
      check("sat_l_pos", pos1, 0);
      check("sat_l_edge", edg1, 1);
      check("sat_l_upd", upd1, 0);
      for (int i = 0; i < 9; i++) begin
         step(1'b0, 1'b1);
         do_ack();
      end
      check("sat_walk_pos", pos1, 9);
      step(1'b0, 1'b1);
      check("sat_r_pos", pos1, 9);
      check("sat_r_edge", edg1, 1);
      check("sat_r_upd", upd1, 0);
      check("sat_r_moves", mov1, 9);
      tick();
      check("sat_edge_once", edg1, 0);
      en1 = 1'b0;

      // 2-bit move counter sticks at 3
      en2 = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         step(1'b0, 1'b1);
         check("m2_moves", mov2, (i > 3) ? 3 : i);
         check("m2_pos", pos2, i);
         do_ack();
      end
      en2 = 1'b0;

      // Asynchronous reset in the middle of a handshake
      en0 = 1'b1;
      step(1'b0, 1'b1);
      check("mid_upd", upd0, 1);
      #2;
      rst = 1'b1;
      #1;
      check("arst_upd", upd0, 0);
      check("arst_pos", pos0, 0);
      check("arst_moves", mov0, 0);
      tick();
      rst = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
